// File: rtl/eindopdracht_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit OCI trace items into 30-bit words of up to 15 items and hands
// them to the trace consumer through a one-entry valid/ready output register.
module eindopdracht_nios2_qsys_0_oci_dct_packer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        item_valid,
   input  logic [1:0]  item_data,
   output logic        item_ready,
   input  logic        flush,
   output logic        dct_valid,
   output logic [29:0] dct_buffer,
   output logic [3:0]  dct_count,
   input  logic        dct_ready,
   input  logic        test_ending,
   output logic        test_has_ended,
   output logic [1:0]  dbg_state
);

   localparam int ITEM_W = 2;
   localparam int ITEMS  = 15;
   localparam logic [3:0] FULL_CNT = 4'(ITEMS);

   // Handshakes: an item moves when item_valid && item_ready, a word moves when
   // dct_valid && dct_ready; a presented word stays stable until it is taken.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ENDED = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [29:0] acc_q, acc_d;
   logic [3:0]  acc_cnt_q, acc_cnt_d;
   logic        out_valid_q, out_valid_d;
   logic [29:0] out_buf_q, out_buf_d;
   logic [3:0]  out_cnt_q, out_cnt_d;
   logic        flush_pend_q, flush_pend_d;

   logic        out_free;
   logic        xfer;
   logic        accept;
   logic [3:0]  slot;

   always_comb begin
      out_free   = !out_valid_q || dct_ready;
      xfer       = out_free && ((acc_cnt_q == FULL_CNT) ||
                                (flush_pend_q && (acc_cnt_q != 4'd0)));
      item_ready = reset_n && (state_q == ST_RUN) &&
                   ((acc_cnt_q != FULL_CNT) || out_free);
      accept     = item_valid && item_ready;
      // A transfer empties the accumulator first, so a same-cycle item lands in slot 0.
      slot       = xfer ? 4'd0 : acc_cnt_q;

      acc_d     = acc_q;
      acc_cnt_d = acc_cnt_q;
      if (xfer) begin
         acc_d     = '0;
         acc_cnt_d = 4'd0;
      end
      if (accept) begin
         acc_d[{slot, 1'b0} +: ITEM_W] = item_data;
         acc_cnt_d                     = slot + 4'd1;
      end

      out_valid_d = out_valid_q;
      out_buf_d   = out_buf_q;
      out_cnt_d   = out_cnt_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_buf_d   = acc_q;
         out_cnt_d   = acc_cnt_q;
      end else if (out_valid_q && dct_ready) begin
         out_valid_d = 1'b0;
      end

      // An empty flush with no incoming item has nothing to emit and is dropped.
      flush_pend_d = flush_pend_q;
      if (xfer) begin
         flush_pend_d = 1'b0;
      end else if ((state_q == ST_RUN) && flush) begin
         flush_pend_d = (acc_cnt_q != 4'd0) || accept;
      end
      if ((state_q == ST_RUN) && test_ending) begin
         flush_pend_d = 1'b1;
      end

      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (test_ending) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((acc_cnt_q == 4'd0) && !out_valid_q) begin
               state_d = ST_ENDED;
            end
         end
         ST_ENDED: begin
            state_d = ST_ENDED;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_RUN;
         acc_q        <= '0;
         acc_cnt_q    <= 4'd0;
         out_valid_q  <= 1'b0;
         out_buf_q    <= '0;
         out_cnt_q    <= 4'd0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         acc_cnt_q    <= acc_cnt_d;
         out_valid_q  <= out_valid_d;
         out_buf_q    <= out_buf_d;
         out_cnt_q    <= out_cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign dct_valid      = out_valid_q;
   assign dct_buffer     = out_buf_q;
   assign dct_count      = out_cnt_q;
   assign test_has_ended = (state_q == ST_ENDED);
   assign dbg_state      = state_q;

endmodule
